// File: rtl/cla_seq_adder.sv
// Sequential adder that walks the operands one byte per cycle through an
// external 8-bit carry-lookahead slice, rippling the carry between bytes.
module cla_seq_adder #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  op_cin,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf,
  output logic                  grp_p,
  output logic [7:0]            cla_a,
  output logic [7:0]            cla_b,
  output logic                  cla_cin,
  input  logic [7:0]            cla_sum,
  input  logic                  cla_cout,
  input  logic                  cla_pg,
  input  logic                  cla_gg
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            c_q, c_d;
  logic            pacc_q, pacc_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    work_q, work_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            grp_p_q, grp_p_d;
  logic            last_byte;
  logic            gg_unused;

  assign gg_unused = cla_gg;
  assign last_byte = (idx_q == IW'(NBYTES - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    c_d     = c_q;
    pacc_d  = pacc_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    grp_p_d = grp_p_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = op_a;
          b_d     = op_b;
          idx_d   = '0;
          c_d     = op_cin;
          pacc_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        work_d[idx_q*8 +: 8] = cla_sum;
        c_d    = cla_cout;
        pacc_d = pacc_q & cla_pg;
        idx_d  = idx_q + IW'(1);
        // Published results live apart from the working sum so they stay
        // stable until this operation completes.
        if (last_byte) begin
          state_d = DONE;
          idx_d   = '0;
          sum_d   = work_d;
          cout_d  = cla_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (cla_sum[7] != a_q[W-1]);
          grp_p_d = pacc_q & cla_pg;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      c_q     <= 1'b0;
      pacc_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      grp_p_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      pacc_q  <= pacc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      grp_p_q <= grp_p_d;
    end
  end

  always_comb begin
    cla_a   = '0;
    cla_b   = '0;
    cla_cin = 1'b0;
    if (state_q == RUN) begin
      cla_a   = a_q[idx_q*8 +: 8];
      cla_b   = b_q[idx_q*8 +: 8];
      cla_cin = c_q;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;
  assign grp_p = grp_p_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder with a behavioural 8-bit CLA slice attached and a
// full-width arithmetic reference model.
module tb_cla_seq_adder;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst, start, op_cin;
  logic [W-1:0]  op_a, op_b;
  logic          busy, done, cout, ovf, grp_p;
  logic [W-1:0]  sum;
  logic [7:0]    cla_a, cla_b, cla_sum;
  logic          cla_cin, cla_cout, cla_pg, cla_gg;
  logic [8:0]    t9, g9;

  int unsigned   errors = 0;
  int unsigned   checks = 0;

  logic [W-1:0]  hold_sum;
  logic          hold_cout, hold_ovf, hold_gp;

  always #5 clk = ~clk;

  // External 8-bit CLA slice
  assign t9       = {1'b0, cla_a} + {1'b0, cla_b} + {8'b0, cla_cin};
  assign g9       = {1'b0, cla_a} + {1'b0, cla_b};
  assign cla_sum  = t9[7:0];
  assign cla_cout = t9[8];
  assign cla_pg   = &(cla_a ^ cla_b);
  assign cla_gg   = g9[8];

  cla_seq_adder #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .start(start),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .grp_p(grp_p), .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_sum(cla_sum), .cla_cout(cla_cout), .cla_pg(cla_pg), .cla_gg(cla_gg)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, b, s);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  function automatic logic ref_gp(input logic [W-1:0] a, b);
    return &(a ^ b);
  endfunction

  // Called on a negedge while idle or in the DONE cycle; returns on the
  // negedge where done is high.
  task automatic run_op(input logic [W-1:0] a, b, input logic cin);
    logic [W:0] r;
    int cyc;
    start = 1'b1; op_a = a; op_b = b; op_cin = cin;
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom; op_cin = 1'($urandom);
    cyc = 1;
    check("busy_first", busy, 1);
    check("cla_a_byte0", cla_a, a[7:0]);
    check("cla_b_byte0", cla_b, b[7:0]);
    check("cla_cin0", cla_cin, cin);
    check("held_sum", sum, hold_sum);
    check("held_cout", cout, hold_cout);
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (!done && busy) check("held_sum_run", sum, hold_sum);
    end
    check("latency", cyc, 5);
    r = ref_add(a, b, cin);
    check("sum", sum, r[W-1:0]);
    check("cout", cout, r[W]);
    check("ovf", ovf, ref_ovf(a, b, r[W-1:0]));
    check("grp_p", grp_p, ref_gp(a, b));
    check("busy_in_done", busy, 0);
    hold_sum = r[W-1:0]; hold_cout = r[W];
    hold_ovf = ref_ovf(a, b, r[W-1:0]); hold_gp = ref_gp(a, b);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("done_drop", done, 0);
    check("busy_idle", busy, 0);
    check("cla_a_idle", cla_a, 0);
    check("cla_b_idle", cla_b, 0);
    check("cla_cin_idle", cla_cin, 0);
    check("sum_hold_idle", sum, hold_sum);
  endtask

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic cin;
                   logic [W-1:0] s; logic co; logic ov; logic gp; } vec_t;
  vec_t dir[4];

  initial begin
    int dones;
    logic [W-1:0] dsum;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0;
    hold_sum = '0; hold_cout = 0; hold_ovf = 0; hold_gp = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_grp_p", grp_p, 0);
    check("rst_cla_a", cla_a, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors with expected values written out
    dir[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    dir[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    dir[2] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    dir[3] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_op(dir[i].a, dir[i].b, dir[i].cin);
      check("dir_sum", sum, dir[i].s);
      check("dir_cout", cout, dir[i].co);
      check("dir_ovf", ovf, dir[i].ov);
      check("dir_grp_p", grp_p, dir[i].gp);
      idle_cycle();
    end

    // Start while busy is ignored
    start = 1'b1; op_a = 32'h12345678; op_b = 32'h11111111; op_cin = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; op_a = 32'hDEADBEEF; op_b = 32'h01010101; op_cin = 1'b1;
    @(negedge clk); start = 1'b0;
    dones = 0; dsum = '0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin dones++; dsum = sum; end
      @(negedge clk);
    end
    check("ignore_dones", dones, 1);
    check("ignore_sum", dsum, 32'h23456789);
    hold_sum = 32'h23456789; hold_cout = 0;
    hold_ovf = 0; hold_gp = ref_gp(32'h12345678, 32'h11111111);

    // Back-to-back: second start lands in the DONE cycle
    run_op(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0);
    run_op(32'h00000001, 32'h00000001, 1'b0);
    check("b2b_sum", sum, 32'h00000002);
    idle_cycle();

    // Reset in the middle of RUN
    start = 1'b1; op_a = 32'hAAAAAAAA; op_b = 32'h55555555; op_cin = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_ovf", ovf, 0);
    check("abort_grp_p", grp_p, 0);
    check("abort_cla_a", cla_a, 0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    hold_sum = '0; hold_cout = 0; hold_ovf = 0; hold_gp = 0;
    run_op(32'h0000FFFF, 32'h00000001, 1'b0);

    // Random regression, optionally back-to-back
    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
